// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared definitions for the SPAD read-side and write-side routers.
//   member_cnt(spad_w, data_w)   : lanes packed into one SPAD word (ceil)
//   group_cnt(router_cnt, mem_cnt): SPAD words needed for all lanes (ceil)
//   state_e                      : input_router FSM states
// -----------------------------------------------------------------------------
package router_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_e;

  function automatic int member_cnt(input int spad_w, input int data_w);
    return (spad_w + data_w - 1) / data_w;
  endfunction

  function automatic int group_cnt(input int router_cnt, input int mem_cnt);
    return (router_cnt + mem_cnt - 1) / mem_cnt;
  endfunction

endpackage

// File: rtl/spad_word_unpacker.sv
// -----------------------------------------------------------------------------
// spad_word_unpacker
// Combinational split of one SPAD word into MEMBER_CNT lanes, member 0 taken
// from the most significant bits. When the members span more bits than the
// word holds, the missing high bits of member 0 read as zero.
// Ports:
//   word_i    : SPAD word
//   members_o : [0:MEMBER_CNT-1] lanes of DATA_WIDTH bits
// -----------------------------------------------------------------------------
module spad_word_unpacker #(
  parameter int SPAD_DATA_WIDTH = 16,
  parameter int DATA_WIDTH      = 8,
  parameter int MEMBER_CNT      = 2
) (
  input  logic [SPAD_DATA_WIDTH-1:0]               word_i,
  output logic [0:MEMBER_CNT-1][DATA_WIDTH-1:0]    members_o
);

  localparam int PAD_W = MEMBER_CNT * DATA_WIDTH;

  logic [PAD_W-1:0] padded;
  assign padded = PAD_W'(word_i);

  for (genvar j = 0; j < MEMBER_CNT; j++) begin : g_member
    assign members_o[j] = padded[(MEMBER_CNT-1-j)*DATA_WIDTH +: DATA_WIDTH];
  end

endmodule

// File: rtl/input_router.sv
// -----------------------------------------------------------------------------
// input_router
// Reads GROUP_CNT packed words from a SPAD starting at a captured base
// address, unpacks them into ROUTER_COUNT lanes and presents all lanes at once
// with a valid/ready handshake.
// Ports:
//   i_clk, i_nrst : clock, asynchronous active-low reset
//   i_start       : start request (only honoured in IDLE)
//   i_base_addr   : first SPAD address, captured with i_start
//   o_rd_en       : SPAD read strobe (registered)
//   o_addr        : SPAD read address (registered, 0 when not reading)
//   i_rd_data     : SPAD data, valid RD_LATENCY cycles after o_rd_en
//   o_data        : unpacked lanes
//   o_valid       : o_data valid, held until i_ready
//   i_ready       : consumer accepts o_data
//   o_busy        : FSM not in IDLE
//   o_done        : one-cycle pulse after acceptance
// -----------------------------------------------------------------------------
module input_router
  import router_pkg::*;
#(
  parameter int SPAD_ADDR_WIDTH = 8,
  parameter int SPAD_DATA_WIDTH = 16,
  parameter int ROUTER_COUNT    = 4,
  parameter int DATA_WIDTH      = 8,
  parameter int RD_LATENCY      = 1
) (
  input  logic                                   i_clk,
  input  logic                                   i_nrst,
  input  logic                                   i_start,
  input  logic [SPAD_ADDR_WIDTH-1:0]             i_base_addr,
  output logic                                   o_rd_en,
  output logic [SPAD_ADDR_WIDTH-1:0]             o_addr,
  input  logic [SPAD_DATA_WIDTH-1:0]             i_rd_data,
  output logic [0:ROUTER_COUNT-1][DATA_WIDTH-1:0] o_data,
  output logic                                   o_valid,
  input  logic                                   i_ready,
  output logic                                   o_busy,
  output logic                                   o_done
);

  localparam int MEMBER_CNT = member_cnt(SPAD_DATA_WIDTH, DATA_WIDTH);
  localparam int GROUP_CNT  = group_cnt(ROUTER_COUNT, MEMBER_CNT);
  localparam int CNT_W      = $clog2(GROUP_CNT + 1);

  state_e                                  state_q, state_d;
  logic [SPAD_ADDR_WIDTH-1:0]              base_q, base_d;
  logic [SPAD_ADDR_WIDTH-1:0]              addr_q, addr_d;
  logic [CNT_W-1:0]                        rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]                        wr_cnt_q, wr_cnt_d;
  logic                                    rd_en_q, rd_en_d;
  logic [RD_LATENCY-1:0]                   pipe_q, pipe_d;
  logic [0:ROUTER_COUNT-1][DATA_WIDTH-1:0] data_q, data_d;
  logic                                    valid_q, valid_d;
  logic                                    done_q, done_d;

  logic [0:MEMBER_CNT-1][DATA_WIDTH-1:0]   members;
  logic                                    ret_vld;

  // The pipe mirrors the SPAD latency, so its tail marks the cycle in which
  // i_rd_data belongs to the oldest outstanding strobe.
  assign ret_vld = pipe_q[RD_LATENCY-1];
  assign pipe_d  = RD_LATENCY'({pipe_q, rd_en_q});

  spad_word_unpacker #(
    .SPAD_DATA_WIDTH (SPAD_DATA_WIDTH),
    .DATA_WIDTH      (DATA_WIDTH),
    .MEMBER_CNT      (MEMBER_CNT)
  ) u_unpack (
    .word_i    (i_rd_data),
    .members_o (members)
  );

  // Lane r belongs to group r/MEMBER_CNT; tail-padding members have no lane
  // and are therefore never written.
  for (genvar r = 0; r < ROUTER_COUNT; r++) begin : g_lane
    localparam int GI = r / MEMBER_CNT;
    localparam int MI = r % MEMBER_CNT;
    assign data_d[r] = (ret_vld && (wr_cnt_q == CNT_W'(GI))) ? members[MI] : data_q[r];
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = ret_vld ? wr_cnt_q + 1'b1 : wr_cnt_q;
    rd_en_d  = 1'b0;
    addr_d   = '0;
    valid_d  = valid_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          base_d   = i_base_addr;
          rd_cnt_d = '0;
          wr_cnt_d = '0;
          state_d  = READ;
        end
      end
      READ: begin
        rd_en_d  = 1'b1;
        addr_d   = base_q + SPAD_ADDR_WIDTH'(rd_cnt_q);
        rd_cnt_d = rd_cnt_q + 1'b1;
        if (rd_cnt_q == CNT_W'(GROUP_CNT - 1)) state_d = DRAIN;
      end
      DRAIN: begin
        // Raise valid together with the last word write so lanes and
        // o_valid appear in the same cycle.
        if (wr_cnt_d == CNT_W'(GROUP_CNT)) begin
          valid_d = 1'b1;
          state_d = OUT;
        end
      end
      OUT: begin
        // Stay in OUT during the o_done cycle so i_start is not seen then.
        if (done_q) begin
          state_d = IDLE;
        end else if (valid_q && i_ready) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q  <= IDLE;
      base_q   <= '0;
      addr_q   <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      rd_en_q  <= 1'b0;
      pipe_q   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      addr_q   <= addr_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      rd_en_q  <= rd_en_d;
      pipe_q   <= pipe_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  assign o_rd_en = rd_en_q;
  assign o_addr  = addr_q;
  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_done  = done_q;
  assign o_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_input_router.sv
// -----------------------------------------------------------------------------
// tb_input_router
// Three router instances share one clock and reset:
//   u_a : defaults (4 lanes, latency 1)
//   u_b : 3 lanes (tail member dropped)
//   u_c : SPAD read latency 3
// Each has its own SPAD model reading a shared memory image.
// -----------------------------------------------------------------------------
module tb_input_router;

  logic clk = 1'b0;
  logic nrst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] mem [0:255];

  int sel = 0;
  logic start_v = 1'b0;
  logic ready_v = 1'b0;
  logic [7:0] base_v = '0;

  logic start_a, start_b, start_c, ready_a, ready_b, ready_c;
  assign start_a = (sel == 0) && start_v;
  assign start_b = (sel == 1) && start_v;
  assign start_c = (sel == 2) && start_v;
  assign ready_a = (sel == 0) && ready_v;
  assign ready_b = (sel == 1) && ready_v;
  assign ready_c = (sel == 2) && ready_v;

  logic rd_en_a, rd_en_b, rd_en_c, valid_a, valid_b, valid_c;
  logic busy_a, busy_b, busy_c, done_a, done_b, done_c;
  logic [7:0] addr_a, addr_b, addr_c;
  logic [15:0] rdat_a, rdat_b, rdat_c;
  logic [15:0] s0_c, s1_c;
  logic [0:3][7:0] data_a, data_c;
  logic [0:2][7:0] data_b;

  input_router u_a (
    .i_clk(clk), .i_nrst(nrst), .i_start(start_a), .i_base_addr(base_v),
    .o_rd_en(rd_en_a), .o_addr(addr_a), .i_rd_data(rdat_a), .o_data(data_a),
    .o_valid(valid_a), .i_ready(ready_a), .o_busy(busy_a), .o_done(done_a));

  input_router #(.ROUTER_COUNT(3)) u_b (
    .i_clk(clk), .i_nrst(nrst), .i_start(start_b), .i_base_addr(base_v),
    .o_rd_en(rd_en_b), .o_addr(addr_b), .i_rd_data(rdat_b), .o_data(data_b),
    .o_valid(valid_b), .i_ready(ready_b), .o_busy(busy_b), .o_done(done_b));

  input_router #(.RD_LATENCY(3)) u_c (
    .i_clk(clk), .i_nrst(nrst), .i_start(start_c), .i_base_addr(base_v),
    .o_rd_en(rd_en_c), .o_addr(addr_c), .i_rd_data(rdat_c), .o_data(data_c),
    .o_valid(valid_c), .i_ready(ready_c), .o_busy(busy_c), .o_done(done_c));

  // SPAD models: latency 1 for a/b, latency 3 for c
  always @(posedge clk) begin
    rdat_a <= mem[addr_a];
    rdat_b <= mem[addr_b];
    s0_c   <= mem[addr_c];
    s1_c   <= s0_c;
    rdat_c <= s1_c;
  end

  int rdcnt [0:2] = '{0, 0, 0};
  always @(posedge clk) begin
    if (rd_en_a) rdcnt[0] <= rdcnt[0] + 1;
    if (rd_en_b) rdcnt[1] <= rdcnt[1] + 1;
    if (rd_en_c) rdcnt[2] <= rdcnt[2] + 1;
  end

  logic        rd_en_m, valid_m, busy_m, done_m;
  logic [7:0]  addr_m;
  logic [31:0] data_m;
  always_comb begin
    rd_en_m = rd_en_a; valid_m = valid_a; busy_m = busy_a; done_m = done_a;
    addr_m = addr_a; data_m = data_a;
    if (sel == 1) begin
      rd_en_m = rd_en_b; valid_m = valid_b; busy_m = busy_b; done_m = done_b;
      addr_m = addr_b; data_m = {8'h00, data_b};
    end else if (sel == 2) begin
      rd_en_m = rd_en_c; valid_m = valid_c; busy_m = busy_c; done_m = done_c;
      addr_m = addr_c; data_m = data_c;
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One full transaction on instance s with timing, address and lane checks.
  task automatic txn(input int s, input logic [7:0] base, input logic [31:0] exp,
                     input int exp_vcyc, input int rdy_wait, input bit poke,
                     input bit early_rdy, input string tag);
    int t0, nrd, vcyc, first_rd, rd0, bad_addr, bad_hold;
    logic [7:0] a0, a1, b1;
    sel = s;
    base_v = base;
    b1 = base + 8'd1;
    ready_v = early_rdy;
    rd0 = rdcnt[s];
    @(negedge clk);
    start_v = 1'b1;
    @(negedge clk);
    start_v = 1'b0;
    t0 = cyc; nrd = 0; vcyc = -1; first_rd = -1; bad_addr = 0;
    a0 = '0; a1 = '0;
    for (int i = 0; i < 30; i++) begin
      start_v = poke && (cyc == t0);
      if (rd_en_m) begin
        if (nrd == 0) begin a0 = addr_m; first_rd = cyc - t0; end
        else if (nrd == 1) a1 = addr_m;
        nrd++;
      end else if (addr_m != 8'h00) begin
        bad_addr++;
      end
      if (valid_m) begin
        vcyc = cyc - t0;
        break;
      end
      @(negedge clk);
    end
    start_v = 1'b0;
    check({tag, " valid_cycle"}, vcyc, exp_vcyc);
    check({tag, " first_rd_cycle"}, first_rd, 1);
    check({tag, " addr0"}, a0, base);
    check({tag, " addr1"}, a1, b1);
    check({tag, " addr_idle_zero"}, bad_addr, 0);
    check({tag, " lanes"}, data_m, exp);
    bad_hold = 0;
    for (int k = 0; k < rdy_wait; k++) begin
      start_v = poke && (k == 1);
      @(negedge clk);
      if (!valid_m || done_m || data_m != exp) bad_hold++;
    end
    if (rdy_wait > 0) check({tag, " hold_stable"}, bad_hold, 0);
    start_v = 1'b0;
    ready_v = 1'b1;
    @(negedge clk);
    ready_v = 1'b0;
    check({tag, " done_pulse"}, {done_m, valid_m, busy_m}, 3'b101);
    @(negedge clk);
    check({tag, " back_idle"}, {done_m, busy_m}, 2'b00);
    check({tag, " lanes_kept"}, data_m, exp);
    repeat (3) @(negedge clk);
    check({tag, " rd_count"}, rdcnt[s] - rd0, 2);
  endtask

  initial begin
    int bad_v;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h10] = 16'hA1B2; mem[8'h11] = 16'hC3D4;
    mem[8'h20] = 16'h1122; mem[8'h21] = 16'h3344;
    mem[8'hFF] = 16'h5566; mem[8'h00] = 16'h7788;

    #2 nrst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs", {rd_en_a, addr_a, valid_a, busy_a, done_a}, '0);
    check("reset_data", data_a, 32'h0);
    nrst = 1'b1;
    @(negedge clk);

    txn(0, 8'h10, 32'hA1B2C3D4, 4, 0, 1'b0, 1'b1, "t1_basic");
    txn(1, 8'h20, 32'h00112233, 4, 0, 1'b0, 1'b0, "t2_three_lanes");
    txn(0, 8'hFF, 32'h55667788, 4, 0, 1'b0, 1'b0, "t3_wrap");
    txn(0, 8'h10, 32'hA1B2C3D4, 4, 5, 1'b0, 1'b0, "t4_backpressure");
    txn(0, 8'h20, 32'h11223344, 4, 3, 1'b1, 1'b0, "t5_start_ignored");

    // Reset in the cycle after the first strobe
    sel = 0; base_v = 8'h10;
    @(negedge clk); start_v = 1'b1;
    @(negedge clk); start_v = 1'b0;
    @(negedge clk);
    check("t6_first_strobe", rd_en_a, 1'b1);
    @(negedge clk);
    nrst = 1'b0;
    #1;
    check("t6_reset_outs", {rd_en_a, addr_a, valid_a, busy_a, done_a}, '0);
    check("t6_reset_data", data_a, 32'h0);
    @(negedge clk);
    nrst = 1'b1;
    bad_v = 0;
    repeat (8) begin
      @(negedge clk);
      if (valid_a || busy_a) bad_v++;
    end
    check("t6_no_valid", bad_v, 0);
    txn(0, 8'h10, 32'hA1B2C3D4, 4, 0, 1'b0, 1'b0, "t6_after_reset");

    txn(2, 8'h10, 32'hA1B2C3D4, 6, 0, 1'b0, 1'b0, "t7_latency3");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
